// File: rtl/mdu_sched_if.sv
// Bundles the MDU's pipeline-facing signals: E-stage issue, D-stage hazard
// query, and the architectural HI/LO outputs.
// master: pipeline side. slave: the mdu_sched block.
interface mdu_sched_if;
  logic        E_start;
  logic [2:0]  E_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_mdu_use;
  logic        busy;
  logic        D_stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        div0_err;

  modport master (
    output E_start, E_op, E_rs_data, E_rt_data, D_mdu_use,
    input  busy, D_stall, HI, LO, div0_err
  );

  modport slave (
    input  E_start, E_op, E_rs_data, E_rt_data, D_mdu_use,
    output busy, D_stall, HI, LO, div0_err
  );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline.
// Captures operands on an E-stage issue, stays busy for a fixed latency, then
// commits the result to HI/LO. Stalls D-stage HI/LO users while busy.
// Optional feature: define MDU_DIV0_TRAP_EN to refuse divides by zero at issue
// and raise a sticky div0_err flag instead.
module mdu_sched #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_sched_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  // Counter holds remaining cycles minus one; commit happens when it reads zero.
  localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);
  localparam logic [3:0] DivCnt = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Multiply results from the latched operands.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Divide via magnitudes so the 0x80000000 / -1 case wraps to 0x80000000
  // without relying on signed-division overflow behaviour.
  logic        div_signed;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  assign div_signed = (op_q == OpDiv);
  assign dvd_mag    = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign dvs_mag    = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign quo_mag    = dvd_mag / dvs_mag;
  assign rem_mag    = dvd_mag % dvs_mag;
  assign quo        = (div_signed && (a_q[31] ^ b_q[31])) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem        = (div_signed && a_q[31]) ? (~rem_mag + 32'd1) : rem_mag;

`ifdef MDU_DIV0_TRAP_EN
  logic div0_q, div0_d;
`endif

  // State, counter, operand and HI/LO registers; reset aborts any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef MDU_DIV0_TRAP_EN
  // Sticky divide-by-zero flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div0_q <= 1'b0;
    end else begin
      div0_q <= div0_d;
    end
  end
`endif

  // Issue decode in IDLE, countdown and commit in MUL/DIV.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV0_TRAP_EN
    div0_d  = div0_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.E_start) begin
          case (bus.E_op)
            OpMult, OpMultu: begin
              a_d     = bus.E_rs_data;
              b_d     = bus.E_rt_data;
              op_d    = bus.E_op;
              cnt_d   = MulCnt;
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
`ifdef MDU_DIV0_TRAP_EN
              if (bus.E_rt_data == 32'd0) begin
                div0_d = 1'b1;
              end else begin
                a_d     = bus.E_rs_data;
                b_d     = bus.E_rt_data;
                op_d    = bus.E_op;
                cnt_d   = DivCnt;
                state_d = StDiv;
              end
`else
              a_d     = bus.E_rs_data;
              b_d     = bus.E_rt_data;
              op_d    = bus.E_op;
              cnt_d   = DivCnt;
              state_d = StDiv;
`endif
            end
            OpMthi:  hi_d = bus.E_rs_data;
            OpMtlo:  lo_d = bus.E_rs_data;
            default: ;
          endcase
        end
      end

      StMul: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          if (op_q == OpMult) begin
            {hi_d, lo_d} = prod_s;
          end else begin
            {hi_d, lo_d} = prod_u;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StDiv: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          // Divide by zero completes the busy period but leaves HI/LO alone.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs; the stall also covers a mult/div issuing in E this cycle.
  logic busy_w;
  logic e_muldiv;
  assign busy_w   = (state_q != StIdle);
  assign e_muldiv = bus.E_start &&
                    (bus.E_op == OpMult || bus.E_op == OpMultu ||
                     bus.E_op == OpDiv  || bus.E_op == OpDivu);

  assign bus.busy    = busy_w;
  assign bus.D_stall = bus.D_mdu_use & (busy_w | e_muldiv);
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
`ifdef MDU_DIV0_TRAP_EN
  assign bus.div0_err = div0_q;
`else
  assign bus.div0_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed vector table, hand-written
// reset/MTHI/MTLO/divide-by-zero sequences, and a randomized run against a
// behavioural model. Honours MDU_DIV0_TRAP_EN when defined.
module tb_mdu_sched;
  localparam int unsigned MulLat = 5;
  localparam int unsigned DivLat = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_sched_if bus ();

  mdu_sched #(
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic start, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic use_hl);
    bus.E_start   = start;
    bus.E_op      = op;
    bus.E_rs_data = rs;
    bus.E_rt_data = rt;
    bus.D_mdu_use = use_hl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Architectural result {HI, LO} straight from the instruction definitions.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = 64'd0;
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: begin
        up = ua * ub;
        r  = 64'(up);
      end
      3'd2: begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        sq = longint'(ua / ub);
        sr = longint'(ua % ub);
        r  = {sr[31:0], sq[31:0]};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int unsigned lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[7];

  // Random-phase model state.
  int          busy_left;
  logic        pend_commit;
  logic [31:0] pend_hi, pend_lo, m_hi, m_lo;
  logic        m_div0;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vecs[0] = '{"mult_neg1x2",  3'd0, 32'hFFFF_FFFF, 32'd2,        MulLat, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{"multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2,        MulLat, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{"div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'd2,        DivLat, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_7_2",     3'd3, 32'd7,         32'd2,        DivLat, 32'd1,         32'd3};
    vecs[4] = '{"div_ovf",      3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DivLat, 32'd0,        32'h8000_0000};
    vecs[5] = '{"mult_3_m4",    3'd0, 32'd3,         32'hFFFF_FFFC, MulLat, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
    vecs[6] = '{"div_7_m2",     3'd2, 32'd7,         32'hFFFF_FFFE, DivLat, 32'd1,         32'hFFFF_FFFD};

    // Reset and idle.
    reset = 1'b1;
    do_reset();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    tick();
    tick();
    tick();
    chk("idle_hi", bus.HI, 32'd0);
    chk("idle_lo", bus.LO, 32'd0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_stall", bus.D_stall, 1'b0);
    chk("idle_div0", bus.div0_err, 1'b0);

    // Reset in the middle of a DIV: busy drops at once, no commit afterwards.
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    chk("middiv_busy", bus.busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < int'(DivLat) + 2; i++) tick();
    chk("abort_lo", bus.LO, 32'd0);
    chk("abort_busy", bus.busy, 1'b0);

    // Vector table, back-to-back, D_mdu_use held high throughout.
    for (int v = 0; v < 7; v++) begin
      drive(1'b1, vecs[v].op, vecs[v].rs, vecs[v].rt, 1'b1);
      #1;
      chk({vecs[v].name, "_stall_start"}, bus.D_stall, 1'b1);
      tick();
      drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
      #1;
      for (int c = 0; c < int'(vecs[v].lat); c++) begin
        chk({vecs[v].name, "_busy"}, bus.busy, 1'b1);
        chk({vecs[v].name, "_stall"}, bus.D_stall, 1'b1);
        tick();
      end
      chk({vecs[v].name, "_done_busy"}, bus.busy, 1'b0);
      chk({vecs[v].name, "_done_stall"}, bus.D_stall, 1'b0);
      chk({vecs[v].name, "_hi"}, bus.HI, vecs[v].exp_hi);
      chk({vecs[v].name, "_lo"}, bus.LO, vecs[v].exp_lo);
    end

    // MULT with D_mdu_use low: no stall at any point.
    drive(1'b1, 3'd0, 32'd6, 32'd7, 1'b0);
    #1;
    chk("nouse_stall_start", bus.D_stall, 1'b0);
    tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    for (int c = 0; c < int'(MulLat); c++) begin
      chk("nouse_stall", bus.D_stall, 1'b0);
      tick();
    end
    chk("nouse_lo", bus.LO, 32'd42);
    chk("nouse_hi", bus.HI, 32'd0);

    // MTHI then MTLO on consecutive cycles.
    drive(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
    tick();
    chk("mthi_hi", bus.HI, 32'h1234_5678);
    chk("mthi_busy", bus.busy, 1'b0);
    drive(1'b1, 3'd5, 32'd9, 32'd0, 1'b0);
    tick();
    chk("mtlo_lo", bus.LO, 32'd9);
    chk("mtlo_hi", bus.HI, 32'h1234_5678);
    chk("mtlo_busy", bus.busy, 1'b0);

    // Divide by zero with HI/LO preloaded.
    drive(1'b1, 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
    tick();
    drive(1'b1, 3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0);
    tick();
    drive(1'b1, 3'd2, 32'd5, 32'd0, 1'b0);
    tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
`ifdef MDU_DIV0_TRAP_EN
    chk("div0_busy", bus.busy, 1'b0);
    chk("div0_err", bus.div0_err, 1'b1);
    tick();
    chk("div0_err_sticky", bus.div0_err, 1'b1);
`else
    for (int c = 0; c < int'(DivLat); c++) begin
      chk("div0_busy", bus.busy, 1'b1);
      chk("div0_err", bus.div0_err, 1'b0);
      tick();
    end
`endif
    chk("div0_done_busy", bus.busy, 1'b0);
    chk("div0_hi", bus.HI, 32'hA5A5_A5A5);
    chk("div0_lo", bus.LO, 32'hA5A5_A5A5);

    // Randomized run against the behavioural model.
    do_reset();
    busy_left   = 0;
    pend_commit = 1'b0;
    pend_hi     = 32'd0;
    pend_lo     = 32'd0;
    m_hi        = 32'd0;
    m_lo        = 32'd0;
    m_div0      = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic        st, use_hl, exp_busy, exp_stall;
      logic [2:0]  op;
      logic [31:0] rs, rt;
      st     = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      rs     = pick();
      rt     = pick();
      use_hl = 1'($urandom_range(0, 1));
      drive(st, op, rs, rt, use_hl);
      #1;
      exp_busy  = (busy_left > 0);
      exp_stall = use_hl && (exp_busy || (st && op < 3'd4));
      chk("rnd_busy", bus.busy, exp_busy);
      chk("rnd_stall", bus.D_stall, exp_stall);
      chk("rnd_hi", bus.HI, m_hi);
      chk("rnd_lo", bus.LO, m_lo);
      chk("rnd_div0", bus.div0_err, m_div0);

      // Model the edge that follows.
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0 && pend_commit) begin
          m_hi = pend_hi;
          m_lo = pend_lo;
        end
      end else if (st) begin
        case (op)
          3'd0, 3'd1: begin
            busy_left          = MulLat;
            pend_commit        = 1'b1;
            {pend_hi, pend_lo} = ref_result(op, rs, rt);
          end
          3'd2, 3'd3: begin
            if (rt == 32'd0) begin
`ifdef MDU_DIV0_TRAP_EN
              m_div0 = 1'b1;
`else
              busy_left   = DivLat;
              pend_commit = 1'b0;
`endif
            end else begin
              busy_left          = DivLat;
              pend_commit        = 1'b1;
              {pend_hi, pend_lo} = ref_result(op, rs, rt);
            end
          end
          3'd4:    m_hi = rs;
          3'd5:    m_lo = rs;
          default: ;
        endcase
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline. It accepts a MULT/MULTU/DIV/DIVU/MTHI/MTLO issue from the E stage and captures the operands. It sequences the operation over a fixed latency with a busy counter, then commits the result to the architectural HI/LO registers. While busy, it asserts a stall to the D stage for any instruction that touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo).

## Interface
Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (≥1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- E_start  input  1  E-stage instruction is an MDU op; qualified by the E-stage pipeline register contents
- E_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others = no-op
- E_rs_data  input  32  forwarded rs operand
- E_rt_data  input  32  forwarded rt operand
- D_mdu_use  input  1  D-stage instruction reads or writes HI/LO or starts the MDU
- busy  output  1  operation in flight
- D_stall  output  1  stall request to F/D registers
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- div0_err  output  1  sticky divide-by-zero flag (see Configuration)

## Operation
- State: IDLE, MUL, DIV; 4-bit down-counter cnt; operand latches a_q, b_q; op_q.
- IDLE:
  - E_start with MULT/MULTU: latch operands, cnt←MUL_LAT−1, go MUL.
  - E_start with DIV/DIVU: latch operands, cnt←DIV_LAT−1, go DIV.
  - MTHI/MTLO: HI (or LO) ← E_rs_data at that edge; stay IDLE; busy never asserted.
- MUL/DIV: cnt decrements each cycle. On the edge where cnt==0:
  - commit result, return to IDLE.
  - MULT: {HI,LO} ← signed 64-bit a_q×b_q.
  - MULTU: {HI,LO} ← unsigned 64-bit a_q×b_q.
  - DIV: LO ← signed quotient, HI ← signed remainder; remainder takes the dividend's sign (truncating division).
  - DIVU: LO ← unsigned quotient, HI ← unsigned remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (b_q==0): HI/LO are left unchanged; the operation otherwise completes normally.
- E_start while busy: ignored. This cannot occur with correct stalling; the bench checks it is ignored.
- Unknown E_op with E_start: no effect.
- busy = (state != IDLE).
- D_stall = D_mdu_use & (busy | (E_start & E_op ∈ {MULT,MULTU,DIV,DIVU})). This is combinational; no bubbles are generated internally.

## Timing
- Reset (reset=0, asynchronous):
  - state IDLE, cnt 0, HI 0, LO 0, div0_err 0, busy 0.
  - Operand latches 0.
  - Mid-operation reset aborts the operation with no commit.
- MULT accepted at edge of cycle t:
  - busy=1 during cycles t+1 … t+MUL_LAT.
  - HI/LO new value visible from cycle t+MUL_LAT+1, when busy=0.
- DIV: same as MULT with DIV_LAT.
- MTHI/MTLO accepted at cycle t: new value visible at t+1.
- Back-to-back: a new start may be accepted in the first cycle busy=0.
- Result commit and a same-cycle E_start cannot coexist, because the state is not IDLE at commit.

## Configuration
- MDU_DIV0_TRAP_EN defined:
  - DIV/DIVU with E_rt_data==0 at start is not issued: state stays IDLE and busy stays 0.
  - div0_err is set the next cycle and stays set until reset.
  - HI/LO are unchanged.
- MDU_DIV0_TRAP_EN undefined:
  - div0_err is tied 0.
  - Divide by zero runs the full DIV_LAT busy period and leaves HI/LO unchanged.

## Test plan
- Reset, then idle 3 cycles → HI=LO=0, busy=0, D_stall=0; assert reset mid-DIV → busy drops immediately, HI/LO stay 0.
- MULT rs=0xFFFFFFFF, rt=2 → busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=−7, rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7, rt=2 → LO=3, HI=1.
- MULT start with D_mdu_use=1 held → D_stall=1 in the start cycle and all 5 busy cycles, 0 in the cycle HI/LO become valid; D_mdu_use=0 → D_stall=0 throughout.
- MTHI rs=0x12345678 then MTLO rs=0x9 on consecutive cycles → HI=0x12345678, LO=9, busy never 1.
- DIV rt=0 with HI=LO=0xA5A5A5A5 preloaded → HI/LO unchanged. With MDU_DIV0_TRAP_EN: busy stays 0 and div0_err=1 next cycle. Without: busy for 10 cycles and div0_err=0.
